// File: rtl/uart_tx_gen.sv
// ============================================================================
// Module   : uart_tx_gen
// Brief    : 8N1 UART transmitter with per-frame latched baud period.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        trmt,
  input  logic [7:0]  tx_data,
  input  logic [15:0] baud_cnt,
  output logic        TX,
  output logic        busy,
  output logic        tx_done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TXING = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'd9;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bit_end;

  assign bit_end = (cnt_q == baud_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      cnt_q   <= 16'd0;
      bit_q   <= 4'd0;
      shift_q <= 9'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (trmt) begin
          state_d = TXING;
          baud_d  = baud_cnt;
          // Shifter holds the data bits followed by the stop bit; start bit goes out now.
          shift_d = {1'b1, tx_data};
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = 16'd0;
          bit_d   = 4'd0;
        end
      end
      TXING: begin
        if (bit_end) begin
          cnt_d = 16'd0;
          if (bit_q == LAST_BIT) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            bit_d   = 4'd0;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[8:1]};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign TX      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_gen.sv
// ============================================================================
// Module   : tb_uart_tx_gen
// Brief    : Randomized self-checking bench for uart_tx_gen against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_gen;

  logic        clk;
  logic        rst;
  logic        trmt;
  logic [7:0]  tx_data;
  logic [15:0] baud_cnt;
  logic        TX;
  logic        busy;
  logic        tx_done;

  int n_cmp;
  int n_bad;

  uart_tx_gen dut (
    .clk      (clk),
    .rst      (rst),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .baud_cnt (baud_cnt),
    .TX       (TX),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request a frame and follow it edge by edge. The model line value at edge k after
  // acceptance is bit floor(k/(b+1)) of {stop, data, start}; edge 10*(b+1) ends the frame.
  // limit caps how many edges are checked (for partial or aborted frames).
  task automatic run_frame(input logic [7:0] d, input logic [15:0] b,
                           input int limit, input bit noise);
    logic [9:0] fb;
    longint     per;
    longint     total;
    longint     last;
    fb       = {1'b1, d, 1'b0};
    per      = longint'(b) + 1;
    total    = 10 * per;
    last     = (longint'(limit) < total) ? longint'(limit) : total;
    tx_data  = d;
    baud_cnt = b;
    trmt     = 1'b1;
    for (longint k = 0; k <= last; k++) begin
      step();
      if (k < total) begin
        check("tx_bit", {31'd0, TX}, {31'd0, fb[k / per]});
        check("busy_on", {31'd0, busy}, 32'd1);
        check("done_low", {31'd0, tx_done}, 32'd0);
      end else begin
        check("tx_idle_end", {31'd0, TX}, 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("done_end", {31'd0, tx_done}, 32'd1);
      end
      if (noise && k + 1 < total) begin
        trmt     = 1'($urandom);
        tx_data  = 8'($urandom);
        baud_cnt = 16'($urandom_range(0, 15));
      end else begin
        trmt = 1'b0;
      end
    end
    trmt = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic exp_done);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_tx", {31'd0, TX}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, tx_done}, {31'd0, exp_done});
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    trmt     = 1'b1;
    tx_data  = 8'h5A;
    baud_cnt = 16'd2;

    // Reset held with trmt asserted: no frame may start.
    #1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_tx", {31'd0, TX}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, tx_done}, 32'd0);
    end
    trmt = 1'b0;
    rst  = 1'b0;
    idle_cycles(2, 1'b0);

    // Reference frame, then a noisy copy that must be unaffected by input changes.
    run_frame(8'hA5, 16'd9, 1 << 30, 1'b0);
    idle_cycles(3, 1'b1);
    run_frame(8'hA5, 16'd9, 1 << 30, 1'b1);
    idle_cycles(3, 1'b1);

    // Single-clock bits, back-to-back on the first idle cycle after done.
    run_frame(8'hFF, 16'd0, 1 << 30, 1'b0);
    run_frame(8'h96, 16'd0, 1 << 30, 1'b0);
    idle_cycles(1, 1'b1);

    // Asynchronous reset in the middle of a frame.
    run_frame(8'hA5, 16'd9, 35, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_tx", {31'd0, TX}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, tx_done}, 32'd0);
    step();
    rst = 1'b0;
    idle_cycles(2, 1'b0);
    run_frame(8'h01, 16'd9, 1 << 30, 1'b0);
    idle_cycles(1, 1'b1);

    // Randomized frames with random idle gaps and noisy inputs.
    for (int f = 0; f < 20; f++) begin
      run_frame(8'($urandom), 16'($urandom_range(0, 12)), 1 << 30, 1'($urandom));
      idle_cycles(int'($urandom_range(0, 3)), 1'b1);
    end

    // Maximum period: start bit must last 65536 clocks before data bit 0 appears.
    run_frame(8'h01, 16'hFFFF, 65540, 1'b0);
    rst = 1'b1;
    #1;
    check("max_abort_tx", {31'd0, TX}, 32'd1);
    step();
    rst = 1'b0;
    idle_cycles(1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_gen.md
UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; asynchronous and active-high.
REQ-003 SHALL have port: trmt  input  1  transmit request; sampled only in IDLE.
REQ-004 SHALL have port: tx_data  input  8  byte to send; latched when trmt is accepted.
REQ-005 SHALL have port: baud_cnt  input  16  bit period minus one, in clocks; latched when trmt is accepted.
REQ-006 SHALL have port: TX  output  1  registered serial line; idle high.
REQ-007 SHALL have port: busy  output  1  high while a frame is on TX.
REQ-008 SHALL have port: tx_done  output  1  sticky frame-complete flag.

Function
REQ-009 SHALL send 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); 10 bits in total.
REQ-010 SHALL hold every bit on TX for exactly baud_cnt+1 clocks, using the latched baud_cnt value.
REQ-011 SHALL implement a 2-state FSM: IDLE and TXING.
REQ-012 IDLE -> TXING SHALL occur on the rising edge where trmt=1 in IDLE. On that edge: latch tx_data and baud_cnt; TX<=0; busy<=1; tx_done<=0; clear bit counter and baud counter.
REQ-013 SHALL ignore trmt while in TXING; latched data and latched baud SHALL NOT change.
REQ-014 Baud counter (16 bit) SHALL increment each TXING clock. When it equals latched baud, it SHALL clear to 0, the shifter SHALL advance one bit, and the 4-bit bit counter SHALL increment.
REQ-015 The baud counter SHALL never wrap; latched baud=16'hFFFF SHALL give 65536 clocks per bit.
REQ-016 TXING -> IDLE SHALL occur on the edge that completes the 10th bit period: TX<=1, busy<=0, tx_done<=1.
REQ-017 Total latency from the accepting edge to the tx_done rising edge SHALL be 10*(baud_cnt+1) clocks.
REQ-018 tx_done SHALL stay high until the next accepted trmt, or until reset.
REQ-019 Earliest back-to-back frame: trmt accepted on the first IDLE cycle after tx_done rises. Guaranteed stop-bit width SHALL stay baud_cnt+1 clocks.
REQ-020 Changes to baud_cnt or tx_data during TXING SHALL NOT affect the frame in progress.
REQ-021 TX SHALL come directly from a flop, with no combinational path from any input to TX.
REQ-022 Latched baud=0 SHALL be legal: 1 clock per bit, 10-clock frame.

Reset
REQ-023 rst=1 SHALL force, asynchronously: state=IDLE, TX=1, busy=0, tx_done=0, all counters=0.
REQ-024 Reset mid-frame SHALL abort the frame immediately, with TX high. No partial frame SHALL resume after reset.
REQ-025 The first trmt after rst is released SHALL be accepted normally.
REQ-026 Shift and latch registers MAY be non-reset, provided no output depends on them while in IDLE.

Verification
REQ-027 Reset: assert rst with trmt=1 -> TX=1, busy=0, tx_done=0 for the whole reset; no frame starts until rst=0.
REQ-028 baud_cnt=9, tx_data=8'hA5, 1-cycle trmt -> TX=0,1,0,1,0,0,1,0,1,1, each held 10 clocks. busy high for 100 clocks. tx_done rises 100 clocks after the accepting edge.
REQ-029 While sending 8'hA5 with baud_cnt=9, pulse trmt with tx_data=8'h3C at clock 40 and change baud_cnt to 3 -> frame identical to REQ-028; no second frame starts.
REQ-030 baud_cnt=0, tx_data=8'hFF -> TX=0 then 1 for 9 clocks. tx_done at clock 10. Second trmt on clock 11 is accepted and tx_done clears.
REQ-031 Assert rst at clock 35 of a baud_cnt=9 frame -> TX=1, busy=0 in the same cycle. After release, trmt with 8'h01 -> clean frame 0,1,0,0,0,0,0,0,0,1.
REQ-032 baud_cnt=16'hFFFF, tx_data=8'h00 -> each bit lasts 65536 clocks; no counter wrap; tx_done at clock 655360.
